// File: rtl/spi_shift_pkg.sv
// spi_shift_pkg: shared FSM state encoding and shift-direction constants
package spi_shift_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} stateT;

    localparam logic DIR_MSB = 1'b0;
    localparam logic DIR_LSB = 1'b1;

endpackage

// File: rtl/spi_bit_counter.sv
// spi_bit_counter: per-frame bit counter with clear, increment and last-bit flag
module spi_bit_counter
    import spi_shift_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] count,
    output logic             lastBit
);

    // Clear when a frame is loaded, step once per accepted strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (inc)
            count <= count + CNT_W'(1);
    end

    assign lastBit = count == CNT_W'(WIDTH - 1);

endmodule

// File: rtl/spi_shift_engine.sv
// spi_shift_engine: SPI frame shift register with FSM; optional parity_out under SPI_SHIFT_PARITY_EN
module spi_shift_engine
    import spi_shift_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] load_data,
    input  logic             lsb_first,
    input  logic             shift_en,
    input  logic             serial_in,
    output logic             serial_out,
    output logic [WIDTH-1:0] parallel_out,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] bit_count
`ifdef SPI_SHIFT_PARITY_EN
    ,
    output logic             parity_out
`endif
);

    stateT            state, nextState;
    logic [WIDTH-1:0] mem, shiftedMem;
    logic             dirLsb, loadEn, shiftEn, lastBit;

    assign shiftedMem   = (dirLsb == DIR_LSB) ? {serial_in, mem[WIDTH-1:1]} : {mem[WIDTH-2:0], serial_in};
    assign serial_out   = (dirLsb == DIR_LSB) ? mem[0] : mem[WIDTH-1];
    assign parallel_out = mem;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= nextState;
    end

    // Next state and control strobes; start and shift_en only act in their own states
    always_comb begin
        nextState = state;
        loadEn    = 1'b0;
        shiftEn   = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    loadEn    = 1'b1;
                    nextState = SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (shift_en) begin
                    shiftEn   = 1'b1;
                    nextState = lastBit ? DONE : SHIFT;
                end
            end
            DONE: begin
                done      = 1'b1;
                nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    // Shift register and direction latch; both hold outside load and shift
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem    <= '0;
            dirLsb <= DIR_MSB;
        end else if (loadEn) begin
            mem    <= load_data;
            dirLsb <= lsb_first;
        end else if (shiftEn) begin
            mem    <= shiftedMem;
        end
    end

    spi_bit_counter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bitCounter (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (loadEn),
        .inc     (shiftEn),
        .count   (bit_count),
        .lastBit (lastBit)
    );

`ifdef SPI_SHIFT_PARITY_EN
    // Capture the XOR of the completed word on the final shift into DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            parity_out <= 1'b0;
        else if (shiftEn && lastBit)
            parity_out <= ^shiftedMem;
    end
`endif

endmodule

// File: tb/tb_spi_shift_engine.sv
// tb_spi_shift_engine: directed self-checking bench for spi_shift_engine (WIDTH 8 and 16)
module tb_spi_shift_engine;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, lsbFirst, shiftEn, serialIn;
    logic [7:0] loadData;
    logic       serialOut, busy, done;
    logic [7:0] parallelOut;
    logic [3:0] bitCount;

    logic        start16, shiftEn16, serialIn16;
    logic [15:0] loadData16;
    logic        serialOut16, busy16, done16;
    logic [15:0] parallelOut16;
    logic [4:0]  bitCount16;
`ifdef SPI_SHIFT_PARITY_EN
    logic parity8, parity16;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    spi_shift_engine #(.WIDTH(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .load_data    (loadData),
        .lsb_first    (lsbFirst),
        .shift_en     (shiftEn),
        .serial_in    (serialIn),
        .serial_out   (serialOut),
        .parallel_out (parallelOut),
        .busy         (busy),
        .done         (done),
        .bit_count    (bitCount)
`ifdef SPI_SHIFT_PARITY_EN
        ,
        .parity_out   (parity8)
`endif
    );

    spi_shift_engine #(.WIDTH(16)) dut16 (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start16),
        .load_data    (loadData16),
        .lsb_first    (1'b0),
        .shift_en     (shiftEn16),
        .serial_in    (serialIn16),
        .serial_out   (serialOut16),
        .parallel_out (parallelOut16),
        .busy         (busy16),
        .done         (done16),
        .bit_count    (bitCount16)
`ifdef SPI_SHIFT_PARITY_EN
        ,
        .parity_out   (parity16)
`endif
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic begin_frame(input logic [7:0] data, input logic lsb);
        start    = 1'b1;
        loadData = data;
        lsbFirst = lsb;
        tick();
        start    = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        start = 0; lsbFirst = 0; shiftEn = 0; serialIn = 0; loadData = 8'h00;
        start16 = 0; shiftEn16 = 0; serialIn16 = 0; loadData16 = 16'h0000;
        #2;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (bitCount !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", bitCount); end
        checks++; if (parallelOut !== 8'h00) begin errors++; $display("FAIL reset_parallel: got %h expected 00", parallelOut); end
        checks++; if (serialOut !== 1'b0) begin errors++; $display("FAIL reset_serial: got %b expected 0", serialOut); end
`ifdef SPI_SHIFT_PARITY_EN
        checks++; if (parity16 !== 1'b0) begin errors++; $display("FAIL reset_parity: got %b expected 0", parity16); end
`endif
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_after_reset: busy got %b expected 0", busy); end
    endtask

    task automatic test_msb_first;
        logic [7:0] tx = 8'hA5;
        logic [7:0] rx = 8'h3C;
        begin_frame(tx, 1'b0);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL msb_busy: got %b expected 1", busy); end
        checks++; if (bitCount !== 4'd0) begin errors++; $display("FAIL msb_count0: got %0d expected 0", bitCount); end
        for (int i = 0; i < 8; i++) begin
            checks++; if (serialOut !== tx[7-i]) begin errors++; $display("FAIL msb_serial[%0d]: got %b expected %b", i, serialOut, tx[7-i]); end
            checks++; if (done !== 1'b0) begin errors++; $display("FAIL msb_early_done[%0d]: got %b expected 0", i, done); end
            shiftEn  = 1'b1;
            serialIn = rx[7-i];
            tick();
            shiftEn  = 1'b0;
        end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL msb_done: got %b expected 1", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL msb_busy_done: got %b expected 0", busy); end
        checks++; if (parallelOut !== rx) begin errors++; $display("FAIL msb_parallel: got %h expected %h", parallelOut, rx); end
        checks++; if (bitCount !== 4'd8) begin errors++; $display("FAIL msb_count8: got %0d expected 8", bitCount); end
        shiftEn = 1'b1;
        tick();
        shiftEn = 1'b0;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL msb_done_width: got %b expected 0", done); end
        checks++; if (parallelOut !== rx) begin errors++; $display("FAIL msb_idle_hold: got %h expected %h", parallelOut, rx); end
        checks++; if (bitCount !== 4'd8) begin errors++; $display("FAIL msb_idle_count: got %0d expected 8", bitCount); end
    endtask

    task automatic test_lsb_first;
        logic [7:0] tx = 8'hA5;
        begin_frame(tx, 1'b1);
        lsbFirst = 1'b0;
        serialIn = 1'b0;
        for (int i = 0; i < 8; i++) begin
            checks++; if (serialOut !== tx[i]) begin errors++; $display("FAIL lsb_serial[%0d]: got %b expected %b", i, serialOut, tx[i]); end
            shiftEn = 1'b1;
            tick();
            shiftEn = 1'b0;
        end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL lsb_done: got %b expected 1", done); end
        checks++; if (parallelOut !== 8'h00) begin errors++; $display("FAIL lsb_parallel: got %h expected 00", parallelOut); end
        tick();
    endtask

    task automatic test_gapped;
        logic [7:0] rx = 8'hC3;
        int doneSeen = 0;
        begin_frame(8'h5A, 1'b0);
        for (int i = 0; i < 8; i++) begin
            for (int g = 0; g < 2; g++) begin
                if (i == 3 && g == 0) begin
                    start    = 1'b1;
                    loadData = 8'h00;
                end
                tick();
                start = 1'b0;
                if (done === 1'b1) doneSeen++;
            end
            checks++; if (bitCount !== 4'(i)) begin errors++; $display("FAIL gap_hold[%0d]: got %0d expected %0d", i, bitCount, i); end
            shiftEn  = 1'b1;
            serialIn = rx[7-i];
            tick();
            shiftEn  = 1'b0;
            if (done === 1'b1) doneSeen++;
            checks++; if (bitCount !== 4'(i + 1)) begin errors++; $display("FAIL gap_step[%0d]: got %0d expected %0d", i, bitCount, i + 1); end
        end
        checks++; if (parallelOut !== rx) begin errors++; $display("FAIL gap_parallel: got %h expected %h", parallelOut, rx); end
        start    = 1'b1;
        loadData = 8'hFF;
        tick();
        start = 1'b0;
        if (done === 1'b1) doneSeen++;
        tick();
        if (done === 1'b1) doneSeen++;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL gap_start_in_done: busy got %b expected 0", busy); end
        checks++; if (doneSeen != 1) begin errors++; $display("FAIL gap_single_done: got %0d pulses expected 1", doneSeen); end
    endtask

    task automatic test_reset_midframe;
        logic [7:0] rx = 8'h96;
        int doneSeen = 0;
        begin_frame(8'h0F, 1'b0);
        serialIn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            shiftEn = 1'b1;
            tick();
            shiftEn = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", busy); end
        checks++; if (bitCount !== 4'd0) begin errors++; $display("FAIL abort_count: got %0d expected 0", bitCount); end
        checks++; if (parallelOut !== 8'h00) begin errors++; $display("FAIL abort_parallel: got %h expected 00", parallelOut); end
        tick();
        if (done === 1'b1) doneSeen++;
        rst_n = 1'b1;
        tick();
        if (done === 1'b1) doneSeen++;
        checks++; if (doneSeen != 0) begin errors++; $display("FAIL abort_no_done: got %0d pulses expected 0", doneSeen); end
        begin_frame(8'h81, 1'b0);
        for (int i = 0; i < 8; i++) begin
            checks++; if (serialOut !== (i == 0 || i == 7)) begin errors++; $display("FAIL post_serial[%0d]: got %b", i, serialOut); end
            shiftEn  = 1'b1;
            serialIn = rx[7-i];
            tick();
            shiftEn  = 1'b0;
        end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL post_done: got %b expected 1", done); end
        checks++; if (parallelOut !== rx) begin errors++; $display("FAIL post_parallel: got %h expected %h", parallelOut, rx); end
        tick();
    endtask

    task automatic test_width16;
        logic [15:0] rxs [2] = '{16'h0007, 16'h0003};
        logic        par [2] = '{1'b1, 1'b0};
        for (int v = 0; v < 2; v++) begin
            logic [15:0] rx = rxs[v];
            start16    = 1'b1;
            loadData16 = 16'hFFFF;
            tick();
            start16 = 1'b0;
            for (int i = 0; i < 16; i++) begin
                shiftEn16  = 1'b1;
                serialIn16 = rx[15-i];
                tick();
                shiftEn16  = 1'b0;
            end
            checks++; if (done16 !== 1'b1) begin errors++; $display("FAIL w16_done[%0d]: got %b expected 1", v, done16); end
            checks++; if (bitCount16 !== 5'd16) begin errors++; $display("FAIL w16_count[%0d]: got %0d expected 16", v, bitCount16); end
            checks++; if (parallelOut16 !== rx) begin errors++; $display("FAIL w16_parallel[%0d]: got %h expected %h", v, parallelOut16, rx); end
`ifdef SPI_SHIFT_PARITY_EN
            checks++; if (parity16 !== par[v]) begin errors++; $display("FAIL w16_parity[%0d]: got %b expected %b", v, parity16, par[v]); end
`else
            if (par[v] === 1'bx) $display("unexpected parity table entry");
`endif
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_msb_first();
        test_lsb_first();
        test_gapped();
        test_reset_midframe();
        test_width16();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
